decode_queue: RTL

- Registered, parametrised RV32I decode stage. It is the successor to the purely combinational control-word decoder.
- Accepts fetched {pc, instruction} with a valid/ready handshake and decodes each one into a control_word_t.
- Flags illegal encodings instead of halting simulation, and buffers decoded words in a DEPTH-entry FIFO feeding the execute stage.
- Sits between fetch and ID/EX; absorbs back-pressure and supports pipeline flush on a taken branch or jump.

---
 rtl/decode_queue.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/decode_queue.sv
// decode_queue: registered RV32I decoder feeding a DEPTH-entry FIFO towards execute.
// Ports: clk, rst (sync, active-low), flush_i (drop all entries and same-cycle enqueue),
//   in_valid_i/in_ready_o/in_pc_i/in_inst_i (fetch side),
//   out_valid_o/out_ready_i/out_pc_o/out_inst_o/out_ctrl_o/out_illegal_o/out_muldiv_o (execute side),
//   count_o (occupancy), illegal_cnt_o (saturating count of illegal words enqueued).
// Optional: define DECODE_QUEUE_RV32M_EN to accept M-extension op_reg encodings.
package decode_queue_pkg;
  localparam logic [6:0] op_lui = 7'b0110111, op_auipc = 7'b0010111, op_jal = 7'b1101111,
    op_jalr = 7'b1100111, op_br = 7'b1100011, op_load = 7'b0000011, op_store = 7'b0100011,
    op_imm = 7'b0010011, op_reg = 7'b0110011;
  localparam logic [2:0] alu_add = 3'd0, alu_sll = 3'd1, alu_sra = 3'd2, alu_sub = 3'd3,
    alu_xor = 3'd4, alu_srl = 3'd5, alu_or = 3'd6, alu_and = 3'd7;
  localparam logic [2:0] cmp_blt = 3'b100, cmp_bltu = 3'b110;
  localparam logic a1_rs1_out = 1'b0, a1_pc_out = 1'b1;
  localparam logic [2:0] a2_i_imm = 3'd0, a2_u_imm = 3'd1, a2_b_imm = 3'd2, a2_s_imm = 3'd3,
    a2_j_imm = 3'd4, a2_rs2_out = 3'd5;
  localparam logic c_rs2_out = 1'b0, c_i_imm = 1'b1;
  localparam logic [3:0] rf_alu_out = 4'd0, rf_br_en = 4'd1, rf_u_imm = 4'd2, rf_lw = 4'd3,
    rf_pc_plus4 = 4'd4, rf_lb = 4'd5, rf_lbu = 4'd6, rf_lh = 4'd7, rf_lhu = 4'd8;
  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [2:0] aluop;
    logic [2:0] cmpop;
    logic       alumux1;
    logic [2:0] alumux2;
    logic       cmpmux;
    logic [3:0] regfilemux;
    logic       load_regfile;
    logic       load_pc;
    logic       branch;
    logic       data_read;
    logic       data_write;
  } control_word_t;
endpackage

module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [31:0]              in_pc_i,
  input  logic [31:0]              in_inst_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [31:0]              out_pc_o,
  output logic [31:0]              out_inst_o,
  output control_word_t            out_ctrl_o,
  output logic                     out_illegal_o,
  output logic                     out_muldiv_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [CNT_W-1:0]         illegal_cnt_o
);
  localparam int aw = $clog2(DEPTH);
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [4:0] rd;
  logic enq, deq, ill, md, rtype_ok;
  control_word_t cw;
  logic [aw-1:0] wptr, rptr;
  logic [31:0] pc_mem [DEPTH];
  logic [31:0] inst_mem [DEPTH];
  control_word_t ctrl_mem [DEPTH];
  logic [DEPTH-1:0] ill_mem, md_mem;
  assign op = in_inst_i[6:0];
  assign rd = in_inst_i[11:7];
  assign f3 = in_inst_i[14:12];
  assign f7 = in_inst_i[31:25];
  assign in_ready_o = count_o != (aw+1)'(DEPTH);
  assign out_valid_o = count_o != '0;
  assign enq = in_valid_i & in_ready_o & ~flush_i;
  assign deq = out_valid_o & out_ready_i & ~flush_i;
  assign rtype_ok = f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
  always_comb begin
    cw = '0;
    cw.opcode = op;
    cw.funct3 = f3;
    cw.aluop = f3;
    cw.cmpop = f3;
    ill = 1'b0;
    md = 1'b0;
    case (op)
      op_lui: begin
        cw.load_regfile = 1'b1;
        cw.regfilemux = rf_u_imm;
      end
      op_auipc: begin
        cw.alumux1 = a1_pc_out;
        cw.alumux2 = a2_u_imm;
        cw.aluop = alu_add;
        cw.load_regfile = 1'b1;
      end
      op_jal: begin
        cw.alumux1 = a1_pc_out;
        cw.alumux2 = a2_j_imm;
        cw.aluop = alu_add;
        cw.load_pc = 1'b1;
        cw.load_regfile = 1'b1;
        cw.regfilemux = rf_pc_plus4;
      end
      op_jalr: begin
        ill = f3 != 3'b000;
        cw.aluop = alu_add;
        cw.load_pc = 1'b1;
        cw.load_regfile = 1'b1;
        cw.regfilemux = rf_pc_plus4;
      end
      op_br: begin
        ill = f3[2:1] == 2'b01;
        cw.alumux1 = a1_pc_out;
        cw.alumux2 = a2_b_imm;
        cw.aluop = alu_add;
        cw.branch = 1'b1;
      end
      op_load: begin
        ill = f3 == 3'b011 || f3[2:1] == 2'b11;
        cw.aluop = alu_add;
        cw.data_read = 1'b1;
        cw.load_regfile = 1'b1;
        cw.regfilemux = f3 == 3'b000 ? rf_lb : f3 == 3'b001 ? rf_lh :
                        f3 == 3'b100 ? rf_lbu : f3 == 3'b101 ? rf_lhu : rf_lw;
      end
      op_store: begin
        ill = f3 > 3'b010;
        cw.alumux2 = a2_s_imm;
        cw.aluop = alu_add;
        cw.data_write = 1'b1;
      end
      op_imm: begin
        ill = (f3 == 3'b001 && f7 != 7'b0000000) ||
              (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000);
        cw.load_regfile = 1'b1;
        cw.aluop = (f3 == 3'b101 && f7[5]) ? alu_sra : f3;
        cw.cmpmux = f3[2:1] == 2'b01 ? c_i_imm : c_rs2_out;
        cw.cmpop = f3 == 3'b011 ? cmp_bltu : f3 == 3'b010 ? cmp_blt : f3;
        cw.regfilemux = f3[2:1] == 2'b01 ? rf_br_en : rf_alu_out;
      end
      op_reg: begin
`ifdef DECODE_QUEUE_RV32M_EN
        md = f7 == 7'b0000001;
`endif
        ill = !(rtype_ok || md);
        cw.alumux2 = a2_rs2_out;
        cw.load_regfile = 1'b1;
        cw.aluop = md ? f3 : f3 == 3'b000 ? (f7[5] ? alu_sub : alu_add) :
                   f3 == 3'b101 ? (f7[5] ? alu_sra : alu_srl) : f3;
        cw.cmpop = !md && f3 == 3'b011 ? cmp_bltu : !md && f3 == 3'b010 ? cmp_blt : f3;
        cw.regfilemux = !md && f3[2:1] == 2'b01 ? rf_br_en : rf_alu_out;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      cw = '0;
      cw.opcode = op;
      cw.funct3 = f3;
    end
    if (rd == 5'd0) cw.load_regfile = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst || flush_i) begin
      wptr <= '0;
      rptr <= '0;
      count_o <= '0;
    end else begin
      if (enq) wptr <= wptr + aw'(1);
      if (deq) rptr <= rptr + aw'(1);
      count_o <= (enq && !deq) ? count_o + (aw+1)'(1) :
                 (!enq && deq) ? count_o - (aw+1)'(1) : count_o;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) illegal_cnt_o <= '0;
    else if (enq && ill && !(&illegal_cnt_o)) illegal_cnt_o <= illegal_cnt_o + CNT_W'(1);
  end
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[wptr] <= in_pc_i;
      inst_mem[wptr] <= in_inst_i;
      ctrl_mem[wptr] <= cw;
      ill_mem[wptr] <= ill;
      md_mem[wptr] <= md;
    end
  end
  // Head fields are gated so an empty queue presents all-zero data.
  assign out_pc_o = out_valid_o ? pc_mem[rptr] : '0;
  assign out_inst_o = out_valid_o ? inst_mem[rptr] : '0;
  assign out_ctrl_o = out_valid_o ? ctrl_mem[rptr] : '0;
  assign out_illegal_o = out_valid_o & ill_mem[rptr];
  assign out_muldiv_o = out_valid_o & md_mem[rptr];
endmodule
